// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with frame-aligned shadow update.
// A new value is held in a shadow register and applied only at the frame wrap, so the display never tears.
module seg7_scan_driver #(
   parameter int SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] value,
   input  logic [7:0]  dp_mask,
   input  logic        update,
   input  logic        blank_lz,
   output logic        busy,
   output logic        frame_tick,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [31:0]      sh_val_q, sh_val_d;
   logic [7:0]       sh_dp_q, sh_dp_d;
   logic [31:0]      d_val_q, d_val_d;
   logic [7:0]       d_dp_q, d_dp_d;
   logic             busy_q, busy_d;
   logic             tick_q, tick_d;
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic             cnt_end;
   logic             wrap;
   logic [3:0]       nibble;
   logic [6:0]       seg_hex;
   logic             blank;

   always_comb begin
      cnt_end  = (cnt_q == CNT_MAX);
      wrap     = cnt_end && (idx_q == 3'd7);
      cnt_d    = cnt_end ? '0 : cnt_q + CNT_W'(1);
      idx_d    = cnt_end ? idx_q + 3'd1 : idx_q;
      tick_d   = wrap;

      sh_val_d = sh_val_q;
      sh_dp_d  = sh_dp_q;
      d_val_d  = d_val_q;
      d_dp_d   = d_dp_q;
      busy_d   = busy_q;
      // Apply takes priority; an update arriving in the apply cycle is dropped.
      if (wrap && busy_q) begin
         d_val_d = sh_val_q;
         d_dp_d  = sh_dp_q;
         busy_d  = 1'b0;
      end else if (update && !busy_q) begin
         sh_val_d = value;
         sh_dp_d  = dp_mask;
         busy_d   = 1'b1;
      end
   end

   always_comb begin
      nibble = d_val_q[{idx_q, 2'b00} +: 4];
      case (nibble)
         4'h0:    seg_hex = 7'h40;
         4'h1:    seg_hex = 7'h79;
         4'h2:    seg_hex = 7'h24;
         4'h3:    seg_hex = 7'h30;
         4'h4:    seg_hex = 7'h19;
         4'h5:    seg_hex = 7'h12;
         4'h6:    seg_hex = 7'h02;
         4'h7:    seg_hex = 7'h78;
         4'h8:    seg_hex = 7'h00;
         4'h9:    seg_hex = 7'h10;
         4'hA:    seg_hex = 7'h08;
         4'hB:    seg_hex = 7'h03;
         4'hC:    seg_hex = 7'h46;
         4'hD:    seg_hex = 7'h21;
         4'hE:    seg_hex = 7'h06;
         default: seg_hex = 7'h0E;
      endcase

      // Leading zero: this nibble and every nibble above it are zero.
      blank = blank_lz && (idx_q != 3'd0) && ((d_val_q >> {idx_q, 2'b00}) == 32'd0);

      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (!blank) begin
         an_d  = ~(8'd1 << idx_q);
         seg_d = seg_hex;
         dp_d  = ~d_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         idx_q    <= 3'd0;
         sh_val_q <= 32'd0;
         sh_dp_q  <= 8'd0;
         d_val_q  <= 32'd0;
         d_dp_q   <= 8'd0;
         busy_q   <= 1'b0;
         tick_q   <= 1'b0;
         an_q     <= 8'hFF;
         seg_q    <= 7'h7F;
         dp_q     <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         sh_val_q <= sh_val_d;
         sh_dp_q  <= sh_dp_d;
         d_val_q  <= d_val_d;
         d_dp_q   <= d_dp_d;
         busy_q   <= busy_d;
         tick_q   <= tick_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
      end
   end

   assign busy       = busy_q;
   assign frame_tick = tick_q;
   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: per-digit expectations are queued per frame
// and compared cycle by cycle while the display scans.
module tb_seg7_scan_driver;

   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] value;
   logic [7:0]  dp_mask;
   logic        update;
   logic        blank_lz;
   logic        busy;
   logic        frame_tick;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int errors = 0;
   int checks = 0;

   logic [15:0] sb[$];

   seg7_scan_driver #(.SCAN_DIV(SD)) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .dp_mask    (dp_mask),
      .update     (update),
      .blank_lz   (blank_lz),
      .busy       (busy),
      .frame_tick (frame_tick),
      .an         (an),
      .seg        (seg),
      .dp         (dp)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] r;
      case (n)
         4'h0: r = 7'h40;  4'h1: r = 7'h79;  4'h2: r = 7'h24;  4'h3: r = 7'h30;
         4'h4: r = 7'h19;  4'h5: r = 7'h12;  4'h6: r = 7'h02;  4'h7: r = 7'h78;
         4'h8: r = 7'h00;  4'h9: r = 7'h10;  4'hA: r = 7'h08;  4'hB: r = 7'h03;
         4'hC: r = 7'h46;  4'hD: r = 7'h21;  4'hE: r = 7'h06;  default: r = 7'h0E;
      endcase
      return r;
   endfunction

   task automatic push_frame(input logic [31:0] v, input logic [7:0] m, input logic blk);
      logic [31:0] upper;
      logic [7:0]  a;
      logic [6:0]  s;
      logic        p;
      for (int i = 0; i < 8; i++) begin
         upper = v >> (4 * i);
         if (blk && i != 0 && upper == 32'd0) begin
            a = 8'hFF; s = 7'h7F; p = 1'b1;
         end else begin
            a = 8'hFF;
            a[i] = 1'b0;
            s = hex7(upper[3:0]);
            p = ~m[i];
         end
         sb.push_back({a, s, p});
      end
   endtask

   task automatic check_frame(input string name);
      logic [15:0] e;
      logic        et;
      for (int d = 0; d < 8; d++) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty at digit %0d", name, d);
            return;
         end
         e = sb.pop_front();
         for (int c = 0; c < SD; c++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== e) begin
               errors++;
               $display("FAIL %s digit%0d cyc%0d: got an=%h seg=%h dp=%b, want an=%h seg=%h dp=%b",
                        name, d, c, an, seg, dp, e[15:8], e[7:1], e[0]);
            end
            et = (d == 7 && c == SD - 1);
            checks++;
            if (frame_tick !== et) begin
               errors++;
               $display("FAIL %s_tick digit%0d cyc%0d: got %b want %b", name, d, c, frame_tick, et);
            end
         end
      end
   endtask

   task automatic wait_tick(input string name);
      bit seen = 1'b0;
      for (int k = 0; k < 80 && !seen; k++) begin
         @(negedge clk);
         if (frame_tick === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: no frame_tick within 80 cycles", name);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; update = 1'b0; value = 32'd0; dp_mask = 8'd0; blank_lz = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
         errors++;
         $display("FAIL reset_out: got an=%h seg=%h dp=%b want an=ff seg=7f dp=1", an, seg, dp);
      end
      checks++;
      if ({busy, frame_tick} !== 2'b00) begin
         errors++;
         $display("FAIL reset_flags: got busy=%b tick=%b want 0 0", busy, frame_tick);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (an !== 8'hFF) begin
         errors++;
         $display("FAIL first_cycle_an: got %h want ff", an);
      end
      push_frame(32'd0, 8'd0, 1'b0);
      push_frame(32'd0, 8'd0, 1'b0);
      check_frame("scan0");
      check_frame("scan1");
   endtask

   task automatic test_update;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_before_update: got %b want 0", busy);
      end
      value = 32'h0123ABCD; dp_mask = 8'h01; update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_rise: got %b want 1", busy);
      end
      value = 32'hFFFFFFFF; dp_mask = 8'hFF; update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_hold: got %b want 1", busy);
      end
      wait_tick("update_wrap");
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_clear: got %b want 0", busy);
      end
      push_frame(32'h0123ABCD, 8'h01, 1'b0);
      push_frame(32'h0123ABCD, 8'h01, 1'b0);
      check_frame("new_val0");
      check_frame("new_val1");
   endtask

   task automatic test_wrap_update;
      repeat (SD * 8 - 1) @(negedge clk);
      checks++;
      if ({frame_tick, busy} !== 2'b00) begin
         errors++;
         $display("FAIL pre_wrap: got tick=%b busy=%b want 0 0", frame_tick, busy);
      end
      value = 32'h00000050; dp_mask = 8'h00; update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      checks++;
      if ({frame_tick, busy} !== 2'b11) begin
         errors++;
         $display("FAIL wrap_capture: got tick=%b busy=%b want 1 1", frame_tick, busy);
      end
      push_frame(32'h0123ABCD, 8'h01, 1'b0);
      check_frame("old_kept");
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wrap_apply_busy: got %b want 0", busy);
      end
      blank_lz = 1'b1;
      push_frame(32'h00000050, 8'h00, 1'b1);
      check_frame("blank_50");
   endtask

   task automatic test_apply_ignore;
      value = 32'd0; dp_mask = 8'hFF; update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL zero_busy: got %b want 1", busy);
      end
      repeat (SD * 8 - 2) @(negedge clk);
      value = 32'hFFFFFFFF; dp_mask = 8'h00; update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      checks++;
      if ({frame_tick, busy} !== 2'b10) begin
         errors++;
         $display("FAIL apply_cycle: got tick=%b busy=%b want 1 0", frame_tick, busy);
      end
      push_frame(32'd0, 8'hFF, 1'b1);
      push_frame(32'd0, 8'hFF, 1'b1);
      check_frame("blank_zero0");
      check_frame("blank_zero1");
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL apply_ignored_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_reset_mid;
      blank_lz = 1'b0;
      value = 32'h12345678; dp_mask = 8'hF0; update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: got %b want 1", busy);
      end
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, frame_tick, an, seg, dp} !== {1'b0, 1'b0, 8'hFF, 7'h7F, 1'b1}) begin
         errors++;
         $display("FAIL mid_reset: got busy=%b tick=%b an=%h seg=%h dp=%b want 0 0 ff 7f 1",
                  busy, frame_tick, an, seg, dp);
      end
      rst = 1'b0;
      push_frame(32'd0, 8'd0, 1'b0);
      push_frame(32'd0, 8'd0, 1'b0);
      check_frame("post_rst0");
      check_frame("post_rst1");
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL post_rst_busy: got %b want 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_update();
      test_wrap_update();
      test_apply_ignore();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
